// File: rtl/enc_binder_pack_tm.sv
// rtl/enc_binder_pack_tm.sv - time-multiplexed binder pack: rotates FEATURES level HVs over ceil(FEATURES/LANES) cycles
// Includes the shared shift table package used by the encoder clusters.
package enc_binder_pkg;
  localparam int NUM_SHIFTS = 16;
  localparam int unsigned SHIFTS [NUM_SHIFTS] = '{
    0, 1, 5, 64, 1023, 1100, 333, 512,
    17, 900, 2, 7, 100, 1024, 250, 999
  };
endpackage

module enc_binder_pack_tm #(
  parameter int HV_DIM       = 1024,
  parameter int FEATURES     = 8,
  parameter int LANES        = 2,
  parameter int SHIFT_OFFSET = 0
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             start_binding,
  input  logic                             unbind,
  input  logic [FEATURES-1:0][HV_DIM-1:0] level_hv,
  output logic                             busy,
  output logic                             done,
  output logic [FEATURES-1:0][HV_DIM-1:0] shifted_hv
);

  localparam int NB = (FEATURES + LANES - 1) / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(HV_DIM) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]                        state_q, state_d;
  logic [BW-1:0]                     batch_cnt_q, batch_cnt_d;
  logic                              unbind_q, unbind_d;
  logic                              done_q, done_d;
  logic [FEATURES-1:0][HV_DIM-1:0]  in_bank_q, in_bank_d;
  logic [FEATURES-1:0][HV_DIM-1:0]  shifted_q, shifted_d;

  logic [HV_DIM-1:0] lane_src;
  logic [HV_DIM-1:0] lane_rot;
  logic [SW-1:0]     lane_amt;
  int                lane_feat;

  // Constant per-feature shift, reduced modulo the HV width.
  function automatic logic [SW-1:0] shift_of(input int f);
    shift_of = SW'(enc_binder_pkg::SHIFTS[SHIFT_OFFSET + f] % HV_DIM);
  endfunction

  always_comb begin
    state_d     = state_q;
    batch_cnt_d = batch_cnt_q;
    unbind_d    = unbind_q;
    done_d      = 1'b0;
    in_bank_d   = in_bank_q;
    shifted_d   = shifted_q;
    lane_src    = '0;
    lane_rot    = '0;
    lane_amt    = '0;
    lane_feat   = 0;

    case (state_q)
      ST_IDLE: begin
        if (start_binding) begin
          state_d     = ST_RUN;
          in_bank_d   = level_hv;
          unbind_d    = unbind;
          batch_cnt_d = '0;
        end
      end
      default: begin
        for (int l = 0; l < LANES; l++) begin
          lane_feat = int'(batch_cnt_q) * LANES + l;
          // Lanes beyond the last feature in a partial batch stay idle.
          if (lane_feat < FEATURES) begin
            lane_src = in_bank_q[lane_feat];
            lane_amt = shift_of(lane_feat);
            if (unbind_q) begin
              lane_rot = (lane_src >> lane_amt) | (lane_src << (HV_DIM - int'(lane_amt)));
            end else begin
              lane_rot = (lane_src << lane_amt) | (lane_src >> (HV_DIM - int'(lane_amt)));
            end
            shifted_d[lane_feat] = lane_rot;
          end
        end
        if (batch_cnt_q == BW'(NB - 1)) begin
          state_d     = ST_IDLE;
          batch_cnt_d = '0;
          done_d      = 1'b1;
        end else begin
          batch_cnt_d = batch_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      batch_cnt_q <= '0;
      unbind_q    <= 1'b0;
      done_q      <= 1'b0;
      in_bank_q   <= '0;
      shifted_q   <= '0;
    end else begin
      state_q     <= state_d;
      batch_cnt_q <= batch_cnt_d;
      unbind_q    <= unbind_d;
      done_q      <= done_d;
      in_bank_q   <= in_bank_d;
      shifted_q   <= shifted_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign shifted_hv = shifted_q;

endmodule

// File: tb/tb_enc_binder_pack_tm.sv
// tb/tb_enc_binder_pack_tm.sv - directed self-checking bench for enc_binder_pack_tm
module tb_enc_binder_pack_tm;
  localparam int D = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  logic start8, unb8, busy8, done8;
  logic [7:0][D-1:0] lv8, sh8;
  logic start5, unb5, busy5, done5;
  logic [4:0][D-1:0] lv5, sh5;

  int n_chk = 0;
  int n_pass = 0;

  // Shift amounts already reduced mod 1024 by hand.
  int S8 [8] = '{0, 1, 5, 64, 1023, 76, 333, 512};
  int S5 [5] = '{64, 1023, 76, 333, 512};

  enc_binder_pack_tm #(.HV_DIM(D), .FEATURES(8), .LANES(2), .SHIFT_OFFSET(0)) dut8 (
    .clk(clk), .nrst(nrst), .start_binding(start8), .unbind(unb8),
    .level_hv(lv8), .busy(busy8), .done(done8), .shifted_hv(sh8)
  );

  enc_binder_pack_tm #(.HV_DIM(D), .FEATURES(5), .LANES(2), .SHIFT_OFFSET(3)) dut5 (
    .clk(clk), .nrst(nrst), .start_binding(start5), .unbind(unb5),
    .level_hv(lv5), .busy(busy5), .done(done5), .shifted_hv(sh5)
  );

  function automatic logic [D-1:0] rot_model(input logic [D-1:0] x, input int s, input bit unb);
    logic [D-1:0] r;
    r = '0;
    for (int j = 0; j < D; j++) begin
      if (!unb) r[(j + s) % D] = x[j];
      else      r[j] = x[(j + s) % D];
    end
    return r;
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] r;
    for (int k = 0; k < D / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run8(input logic [7:0][D-1:0] hv, input bit u, output int lat);
    lv8 = hv; unb8 = u; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; start8 = 1'b0; start5 = 1'b0; unb8 = 1'b0; unb5 = 1'b0;
    lv8 = '0; lv5 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy8, done8, busy5, done5} !== 4'b0 || sh8 !== '0 || sh5 !== '0)
      $display("FAIL reset_state: busy8=%b done8=%b busy5=%b done5=%b sh_nonzero=%b required all 0",
               busy8, done8, busy5, done5, (sh8 !== '0) || (sh5 !== '0));
    else n_pass++;
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({busy8, done8, busy5, done5} !== 4'b0 || sh8 !== '0)
        $display("FAIL idle_cycle%0d: busy8=%b done8=%b busy5=%b done5=%b required 0 and shifted 0",
                 c, busy8, done8, busy5, done5);
      else n_pass++;
    end
  endtask

  task automatic test_bind_onehot();
    logic [7:0][D-1:0] exp;
    logic [D-1:0] one;
    one = 1;
    exp = '0;
    for (int f = 0; f < 8; f++) lv8[f] = one;
    unb8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_chk++;
    if (busy8 !== 1'b1 || done8 !== 1'b0)
      $display("FAIL onehot_accept: busy=%b done=%b required busy=1 done=0", busy8, done8);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      exp[2*(k-1)]     = one << S8[2*(k-1)];
      exp[2*(k-1) + 1] = one << S8[2*(k-1) + 1];
      n_chk++;
      if (sh8 !== exp)
        $display("FAIL onehot_edge%0d_data: batch registers differ from required pattern (low word got %h required %h)",
                 k, sh8[2*(k-1)][63:0], exp[2*(k-1)][63:0]);
      else n_pass++;
      n_chk++;
      if (done8 !== (k == 4) || busy8 !== (k < 4))
        $display("FAIL onehot_edge%0d_flags: busy=%b done=%b required busy=%b done=%b",
                 k, busy8, done8, (k < 4), (k == 4));
      else n_pass++;
    end
  endtask

  task automatic test_round_trip();
    logic [7:0][D-1:0] orig, bound;
    int lat;
    for (int f = 0; f < 8; f++) orig[f] = rand_hv();
    run8(orig, 1'b0, lat);
    n_chk++;
    if (lat !== 4) $display("FAIL rt_bind_latency: got %0d required 4", lat);
    else n_pass++;
    for (int f = 0; f < 8; f++) begin
      n_chk++;
      if (sh8[f] !== rot_model(orig[f], S8[f], 1'b0) || $countones(sh8[f]) != $countones(orig[f]))
        $display("FAIL rt_bind_f%0d: got low %h required low %h", f, sh8[f][63:0],
                 rot_model(orig[f], S8[f], 1'b0) & {{(D-64){1'b0}}, {64{1'b1}}});
      else n_pass++;
    end
    bound = sh8;
    run8(bound, 1'b1, lat);
    n_chk++;
    if (lat !== 4) $display("FAIL rt_unbind_latency: got %0d required 4", lat);
    else n_pass++;
    for (int f = 0; f < 8; f++) begin
      n_chk++;
      if (sh8[f] !== orig[f] || $countones(sh8[f]) != $countones(bound[f]))
        $display("FAIL rt_unbind_f%0d: got low %h required low %h", f, sh8[f][63:0], orig[f][63:0]);
      else n_pass++;
    end
  endtask

  task automatic test_partial();
    logic [4:0][D-1:0] hv;
    int lat;
    for (int f = 0; f < 5; f++) hv[f] = rand_hv();
    lv5 = hv; unb5 = 1'b0; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done5) begin
        lat = c;
        break;
      end
    end
    n_chk++;
    if (lat !== 3) $display("FAIL partial_latency: got %0d required 3", lat);
    else n_pass++;
    for (int f = 0; f < 5; f++) begin
      n_chk++;
      if (sh5[f] !== rot_model(hv[f], S5[f], 1'b0))
        $display("FAIL partial_f%0d: got low %h", f, sh5[f][63:0]);
      else n_pass++;
    end
    n_chk++;
    if ($isunknown(sh5) || $isunknown({busy5, done5}))
      $display("FAIL partial_xfree: unknown bits present=1 required 0");
    else n_pass++;
  endtask

  task automatic test_busy_back_to_back();
    logic [7:0][D-1:0] a, b, c;
    int lat;
    for (int f = 0; f < 8; f++) begin
      a[f] = rand_hv(); b[f] = rand_hv(); c[f] = rand_hv();
    end
    lv8 = a; unb8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; lv8 = b; unb8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_chk++;
    if (busy8 !== 1'b1 || done8 !== 1'b0)
      $display("FAIL busy_ignore_flags: busy=%b done=%b required busy=1 done=0", busy8, done8);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (done8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL busy_ignore_done: done=%b busy=%b required done=1 busy=0", done8, busy8);
    else n_pass++;
    for (int f = 0; f < 8; f++) begin
      n_chk++;
      if (sh8[f] !== rot_model(a[f], S8[f], 1'b0))
        $display("FAIL busy_ignore_f%0d: got low %h required first-op result", f, sh8[f][63:0]);
      else n_pass++;
    end
    lv8 = c; unb8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_chk++;
    if (busy8 !== 1'b1 || done8 !== 1'b0)
      $display("FAIL b2b_accept: busy=%b done=%b required busy=1 done=0", busy8, done8);
    else n_pass++;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    n_chk++;
    if (lat !== 4) $display("FAIL b2b_latency: got %0d required 4", lat);
    else n_pass++;
    for (int f = 0; f < 8; f++) begin
      n_chk++;
      if (sh8[f] !== rot_model(c[f], S8[f], 1'b0))
        $display("FAIL b2b_f%0d: got low %h", f, sh8[f][63:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0][D-1:0] d;
    int lat;
    bit saw_done;
    for (int f = 0; f < 8; f++) d[f] = rand_hv();
    lv8 = d; unb8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sh8 !== '0)
      $display("FAIL midreset_state: busy=%b done=%b sh_nonzero=%b required all 0",
               busy8, done8, sh8 !== '0);
    else n_pass++;
    nrst = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done = 1'b1;
    end
    n_chk++;
    if (saw_done) $display("FAIL midreset_no_done: activity seen=1 required 0");
    else n_pass++;
    run8(d, 1'b0, lat);
    n_chk++;
    if (lat !== 4) $display("FAIL midreset_fresh_latency: got %0d required 4", lat);
    else n_pass++;
    for (int f = 0; f < 8; f++) begin
      n_chk++;
      if (sh8[f] !== rot_model(d[f], S8[f], 1'b0))
        $display("FAIL midreset_fresh_f%0d: got low %h", f, sh8[f][63:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_bind_onehot();
    test_round_trip();
    test_partial();
    test_busy_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
